// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed eight-digit seven-segment scan controller.
// A divider steps a digit index through 0..7. The displayed value comes
// from a shadow register. That register changes only at frame boundaries,
// so a new value never tears across one scan. Outputs are registered and
// active-low.
module disp_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic        lz_blank,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  led_en,
    output logic [7:0]  led_cx
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    // A divider below 2 has no meaningful dwell time; stop elaboration.
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("disp_scan_ctrl: SCAN_DIV must be >= 2");
    end

    // Hex digit to segments {a,b,c,d,e,f,g}, active-low.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      pending_q, pending_d;
    logic             pend_q, pend_d;
    logic [7:0]       led_en_q, led_en_d;
    logic [7:0]       led_cx_q, led_cx_d;

    logic             tick;
    logic             frame_tick;
    logic [3:0]       digit_nib;
    logic             upper_zero;
    logic             blank_lz;

    // Scan timing: the divider counts while enabled and the index advances on each tick.
    always_comb begin
        // NOTE: every always_comb output gets a default first. Without one, any
        //       path that skips an assignment infers a latch.
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        tick       = en && (cnt_q == CNT_MAX);
        frame_tick = tick && (idx_q == 3'd7);
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
        if (tick) begin
            idx_d = idx_q + 3'd1;
        end
    end

    // Double buffering: loads land in pending, and pending moves to shadow only between frames.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        if (frame_tick) begin
            if (load) begin
                // A load on the boundary bypasses pending and shows from digit 0.
                shadow_d = data_in;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                shadow_d = pending_q;
                pend_d   = 1'b0;
            end
        end else if (load) begin
            pending_d = data_in;
            pend_d    = 1'b1;
        end
    end

    // Output decode: select the current digit, blank leading zeros, and apply the decimal point.
    always_comb begin
        digit_nib  = shadow_q[{idx_q, 2'b00} +: 4];
        upper_zero = ((shadow_q >> {idx_q, 2'b00}) == 32'd0);
        blank_lz   = lz_blank && (idx_q != 3'd0) && upper_zero;
        led_en_d   = 8'hFF;
        led_cx_d   = 8'hFF;
        if (en) begin
            led_en_d = ~(8'd1 << idx_q);
            if (!blank_lz) begin
                led_cx_d = {seg_decode(digit_nib), ~dp_mask[idx_q]};
            end
        end
    end

    // State registers. Asynchronous reset clears scan position, both buffers and the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: pending is reset along with its flag. A reset must discard an
            //       unapplied load, and an all-zero pending keeps the buffer state fully defined.
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            shadow_q  <= 32'd0;
            pending_q <= 32'd0;
            pend_q    <= 1'b0;
            led_en_q  <= 8'hFF;
            led_cx_q  <= 8'hFF;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. All flops
            //       then sample pre-edge values and no ordering race can occur.
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            led_en_q  <= led_en_d;
            led_cx_q  <= led_cx_d;
        end
    end

    assign led_en = led_en_q;
    assign led_cx = led_cx_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with SCAN_DIV = 4.
module tb_disp_scan_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [7:0]  dp_mask = 8'd0;
    logic [7:0]  led_en;
    logic [7:0]  led_cx;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int          m_cnt;
    int          m_idx;
    logic [31:0] m_shadow;
    logic [31:0] m_pending;
    bit          m_pend;

    // Values expected on the outputs after the most recent clock.
    logic [7:0] exp_en;
    logic [7:0] exp_cx;
    int         last_idx;

    // Full segment bytes with the decimal point off.
    logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    disp_scan_ctrl #(.SCAN_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .load     (load),
        .lz_blank (lz_blank),
        .dp_mask  (dp_mask),
        .led_en   (led_en),
        .led_cx   (led_cx)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_cnt     = 0;
        m_idx     = 0;
        m_shadow  = 32'd0;
        m_pending = 32'd0;
        m_pend    = 1'b0;
    endtask

    // Predict this edge's outputs and advance the model, then clock the DUT.
    // Inputs are changed by callers only after this returns, at posedge + 1.
    task automatic step();
        logic [31:0] upper;
        bit          tick;
        bit          frame;
        last_idx = m_idx;
        if (rst || !en) begin
            exp_en = 8'hFF;
            exp_cx = 8'hFF;
        end else begin
            upper  = m_shadow >> (4 * m_idx);
            exp_en = ~(8'd1 << m_idx);
            if (lz_blank && m_idx != 0 && upper == 32'd0)
                exp_cx = 8'hFF;
            else
                exp_cx = (seg_tab[upper[3:0]] & 8'hFE) | {7'd0, ~dp_mask[m_idx]};
        end
        if (!rst) begin
            tick  = en && (m_cnt == DIV - 1);
            frame = tick && (m_idx == 7);
            if (en) m_cnt = tick ? 0 : m_cnt + 1;
            if (tick) m_idx = (m_idx + 1) % 8;
            if (frame && load) begin
                m_shadow = data_in;
                m_pend   = 1'b0;
            end else begin
                if (frame && m_pend) begin
                    m_shadow = m_pending;
                    m_pend   = 1'b0;
                end
                if (load) begin
                    m_pending = data_in;
                    m_pend    = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] want_en;
        #2 rst = 1'b1;
        m_reset();
        #1;
        n_checks++;
        if (led_en !== 8'hFF || led_cx !== 8'hFF)
            $display("FAIL async_reset: got en=%h cx=%h expected FF/FF", led_en, led_cx);
        else n_pass++;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (led_en !== 8'hFF || led_cx !== 8'hFF)
                $display("FAIL reset_hold: cycle %0d got en=%h cx=%h expected FF/FF", i, led_en, led_cx);
            else n_pass++;
        end
        rst = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            step();
            want_en = ~(8'd1 << (((k - 1) / DIV) % 8));
            n_checks++;
            if (led_en !== want_en || led_cx !== 8'h03)
                $display("FAIL reset_scan: edge %0d got en=%h cx=%h expected %h/03", k, led_en, led_cx, want_en);
            else n_pass++;
        end
    endtask

    task automatic test_tearing();
        logic [7:0] tear_exp [8] = '{8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03};
        int phase = 0;
        int seen  = 0;
        for (int g = 0; g < 100 && m_idx != 3; g++) step();
        n_checks++;
        if (m_idx != 3) $display("FAIL tear_wait: timeout reaching idx 3");
        else n_pass++;
        load    = 1'b1;
        data_in = 32'h01234567;
        step();
        load = 1'b0;
        for (int g = 0; g < 200 && seen < 32; g++) begin
            step();
            if (phase == 0 && last_idx == 0) phase = 1;
            n_checks++;
            if (phase == 0) begin
                if (led_cx !== 8'h03)
                    $display("FAIL tear_old: digit %0d got %h expected 03", last_idx, led_cx);
                else n_pass++;
            end else begin
                seen++;
                if (led_cx !== tear_exp[last_idx])
                    $display("FAIL tear_new: digit %0d got %h expected %h", last_idx, led_cx, tear_exp[last_idx]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_lz();
        logic [7:0] want;
        lz_blank = 1'b1;
        load     = 1'b1;
        data_in  = 32'h000000A5;
        step();
        load = 1'b0;
        for (int g = 0; g < 100 && !(m_shadow == 32'hA5 && !m_pend && m_idx == 0 && m_cnt == 0); g++) step();
        n_checks++;
        if (!(m_shadow == 32'hA5 && m_idx == 0 && m_cnt == 0)) $display("FAIL lz_wait: timeout for A5 frame");
        else n_pass++;
        for (int i = 0; i < 8 * DIV; i++) begin
            step();
            want = (last_idx >= 2) ? 8'hFF : ((last_idx == 1) ? 8'h11 : 8'h49);
            n_checks++;
            if (led_cx !== want || led_en !== ~(8'd1 << last_idx))
                $display("FAIL lz_a5: digit %0d got en=%h cx=%h expected cx=%h", last_idx, led_en, led_cx, want);
            else n_pass++;
        end
        load    = 1'b1;
        data_in = 32'd0;
        step();
        load = 1'b0;
        for (int g = 0; g < 100 && !(m_shadow == 32'd0 && !m_pend && m_idx == 0 && m_cnt == 0); g++) step();
        n_checks++;
        if (!(m_shadow == 32'd0 && m_idx == 0 && m_cnt == 0)) $display("FAIL lz_wait0: timeout for zero frame");
        else n_pass++;
        for (int i = 0; i < 8 * DIV; i++) begin
            step();
            want = (last_idx == 0) ? 8'h03 : 8'hFF;
            n_checks++;
            if (led_cx !== want)
                $display("FAIL lz_zero: digit %0d got %h expected %h", last_idx, led_cx, want);
            else n_pass++;
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_enable_dp();
        dp_mask = 8'h20;
        for (int g = 0; g < 100 && !(m_idx == 5 && m_cnt == 2); g++) step();
        n_checks++;
        if (!(m_idx == 5 && m_cnt == 2)) $display("FAIL en_wait: timeout reaching idx 5");
        else n_pass++;
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (led_en !== 8'hFF || led_cx !== 8'hFF)
                $display("FAIL en_off: cycle %0d got en=%h cx=%h expected FF/FF", i, led_en, led_cx);
            else n_pass++;
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (i < 2) begin
                if (led_en !== 8'hDF || led_cx !== 8'h02)
                    $display("FAIL en_resume: cycle %0d got en=%h cx=%h expected DF/02", i, led_en, led_cx);
                else n_pass++;
            end else begin
                if (led_en !== 8'hBF || led_cx !== 8'h03)
                    $display("FAIL en_next: got en=%h cx=%h expected BF/03", led_en, led_cx);
                else n_pass++;
            end
        end
        dp_mask = 8'h00;
    endtask

    task automatic test_coincidence();
        for (int g = 0; g < 100 && !(m_idx == 7 && m_cnt == DIV - 1); g++) step();
        n_checks++;
        if (!(m_idx == 7 && m_cnt == DIV - 1)) $display("FAIL coin_wait: timeout reaching frame boundary");
        else n_pass++;
        load    = 1'b1;
        data_in = 32'hFFFFFFFF;
        step();
        load = 1'b0;
        for (int i = 0; i < DIV + 1; i++) begin
            step();
            n_checks++;
            if (led_en !== ((i < DIV) ? 8'hFE : 8'hFD) || led_cx !== 8'h71)
                $display("FAIL coincidence: cycle %0d got en=%h cx=%h expected cx=71", i, led_en, led_cx);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] want_en;
        for (int g = 0; g < 10 && m_cnt != 0; g++) step();
        load    = 1'b1;
        data_in = 32'h12345678;
        step();
        load = 1'b0;
        #2 rst = 1'b1;
        m_reset();
        #1;
        n_checks++;
        if (led_en !== 8'hFF || led_cx !== 8'hFF)
            $display("FAIL mid_reset_async: got en=%h cx=%h expected FF/FF", led_en, led_cx);
        else n_pass++;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            want_en = ~(8'd1 << (((k - 1) / DIV) % 8));
            n_checks++;
            if (led_en !== want_en || led_cx !== 8'h03)
                $display("FAIL mid_reset_scan: edge %0d got en=%h cx=%h expected %h/03", k, led_en, led_cx, want_en);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom % 8) != 0;
            load    = ($urandom % 12) == 0;
            data_in = $urandom;
            if ($urandom % 50 == 0) lz_blank = ~lz_blank;
            if ($urandom % 40 == 0) dp_mask = 8'($urandom);
            step();
            n_checks++;
            if (led_en !== exp_en || led_cx !== exp_cx)
                $display("FAIL random: cycle %0d got en=%h cx=%h expected %h/%h", i, led_en, led_cx, exp_en, exp_cx);
            else n_pass++;
        end
        load = 1'b0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_tearing();
        test_lz();
        test_enable_dp();
        test_coincidence();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
